decode_queue: RTL and testbench
===============================

Name: decode_queue

Overview:
- Registered, flow-controlled successor to the combinational decode stage.
- Accepts fetched instructions over a valid/ready handshake and decodes them: fields, immediate, per-format operand-usage flags.
- Buffers decoded bundles in a parametrised FIFO and presents the head to execute.
- Holds the head back on a load-use hazard and supports a single-cycle flush for branch redirect.

Parameters:
- DWIDTH, 32, instruction/data width; only 32 supported, other values are an elaboration error.
- AWIDTH, 32, PC width.
- DEPTH, 2, FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush_i  in  1  discard all buffered and incoming instructions
- in_valid_i  in  1  fetch presents an instruction
- in_ready_o  out  1  queue can accept
- insn_i  in  DWIDTH  instruction word
- pc_i  in  AWIDTH  instruction PC
- out_valid_o  out  1  head bundle valid and not stalled
- out_ready_i  in  1  execute accepts head
- pc_o  out  AWIDTH  head PC
- insn_o  out  DWIDTH  head instruction
- opcode_o  out  7  head opcode
- rd_o, rs1_o, rs2_o  out  5 each  register IDs, zeroed when unused
- funct3_o  out  3  funct3
- funct7_o  out  7  funct7
- shamt_o  out  5  shift amount
- imm_o  out  DWIDTH  sign-extended immediate
- uses_rs1_o, uses_rs2_o, writes_rd_o  out  1 each  operand-usage flags
- ex_is_load_i  in  1  instruction in execute is a load
- ex_rd_i  in  5  destination register of that load
- illegal_o  out  1  head opcode unrecognised (see Optional Feature)

Behaviour:
- Decode happens combinationally on insn_i before the push. The FIFO stores the full decoded bundle, so outputs come directly from the head entry (registered).
- Latency: an instruction pushed in cycle N is visible on the outputs in cycle N+1.
- Field usage per format:
  - R: rs1, rs2, rd used.
  - I (ITYPE, LOAD, JALR): rs1 and rd used; rs2_o=0.
  - S/B: rs1 and rs2 used; rd_o=0.
  - U/J: rd used; rs1_o=rs2_o=0.
  - Unknown opcode: all fields raw, all usage flags 0.
- writes_rd_o is forced to 0 when rd=0.
- Immediate:
  - I: sext(insn[31:20]).
  - S: sext({insn[31:25],insn[11:7]}).
  - B: sext({insn[31],insn[7],insn[30:25],insn[11:8],0}).
  - U: {insn[31:12],12'b0}.
  - J: sext({insn[31],insn[19:12],insn[20],insn[30:21],0}).
  - Other: 0.
- shamt_o = insn[24:20] for OP-IMM SLLI/SRLI/SRAI, else 0.
- Pointers are log2(DEPTH)+1 bits; the extra MSB distinguishes full from empty. Count is 0..DEPTH.
- in_ready_o = !full || pop_this_cycle. Push on the same cycle as a pop when full is allowed.
- Push = in_valid_i && in_ready_o && !flush_i. Pop = out_valid_o && out_ready_i.
- Hazard: ex_is_load_i && ex_rd_i!=0 && ((uses_rs1 && rs1==ex_rd_i) || (uses_rs2 && rs2==ex_rd_i)) on the head.
  - While the hazard is active, out_valid_o=0 and the head is held. Output data stays stable.
- out_valid_o = !empty && !hazard.
- flush_i: on the next edge both pointers and the count return to 0. Any push in that cycle is dropped; a pop in that cycle is still consumed. flush_i outranks push.
- Simultaneous push and pop when empty: no bypass. The pushed entry appears next cycle.
- Reset (and on any cycle rst is asserted mid-operation):
  - Queue empty; out_valid_o=0; in_ready_o=1.
  - All data outputs 0 via a zeroed head entry; illegal_o=0.
- Output data is unspecified-but-stable while out_valid_o=0 and not empty. It must not change unless a pop or flush occurs.

Optional Feature:
- Macro DECODE_ILLEGAL_CHECK_EN.
- When defined: an unrecognised opcode, or funct7 not in {0x00,0x20} for R-type/shift, sets illegal bit in the bundle; illegal_o reflects the head entry.
- When undefined: illegal_o tied to 0 and no bit stored.

Decomposition:
- Opcode, funct3 and funct7 constants (OPCODE_RTYPE, ..., FUNCT3_SLL, FUNCT3_SRL_SRA) go in the shared constants package.
- The package also gains a decoded_bundle_t packed struct and an insn_fmt_e enum {FMT_R,FMT_I,FMT_S,FMT_B,FMT_U,FMT_J,FMT_X}.
- One sub-module is natural: decode_fields, the combinational insn to decoded_bundle_t decoder including imm generation. decode_queue instantiates it and owns the FIFO, handshake and hazard logic.

Test Plan:
- Push addi x1,x2,5 (0x00510093, pc 0x1000) with out_ready_i=1:
  - next cycle out_valid_o=1, rd=1, rs1=2, rs2=0, imm=5, uses_rs2=0, writes_rd=1.
- out_ready_i=0, push 3 instructions with DEPTH=2:
  - in_ready_o drops after 2 pushes.
  - The third is accepted on the cycle out_ready_i returns to 1, and the order is preserved.
- Head sw x5,0(x1) (0x0050A023), ex_is_load_i=1, ex_rd_i=5:
  - out_valid_o=0 and the head is held.
  - Deassert ex_is_load_i: out_valid_o=1, rd=0, imm=0.
  - Same stimulus with ex_rd_i=0: no stall.
- Two entries queued, assert flush_i together with in_valid_i:
  - next cycle empty, out_valid_o=0, flushed instruction never appears.
- Reset mid-stream with a full queue:
  - next cycle out_valid_o=0, in_ready_o=1, outputs 0.
- With DECODE_ILLEGAL_CHECK_EN, push 0xFFFFFFFF: illegal_o=1 at head. Without the macro: illegal_o=0.
- Push jal x1,-4 (0xFFDFF0EF): imm=0xFFFFFFFC, rs1=rs2=0, writes_rd=1.

Source files
------------

// File: rtl/decode_queue_pkg.sv
// Shared decode constants, bundle/format types and opcode classification helpers.
// The bundle carries an illegal bit only when DECODE_ILLEGAL_CHECK_EN is defined.
package decode_queue_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPCODE_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPCODE_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

    localparam logic [2:0] FUNCT3_SLL     = 3'b001;
    localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;

    localparam logic [6:0] FUNCT7_BASE = 7'h00;
    localparam logic [6:0] FUNCT7_ALT  = 7'h20;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_X
    } insn_fmt_e;

    typedef struct packed {
`ifdef DECODE_ILLEGAL_CHECK_EN
        logic            illegal;
`endif
        logic [XLEN-1:0] insn;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      shamt;
        logic [XLEN-1:0] imm;
        logic            uses_rs1;
        logic            uses_rs2;
        logic            writes_rd;
    } decoded_bundle_t;

    function automatic insn_fmt_e opcode_fmt(input logic [6:0] opcode);
        insn_fmt_e fmt;
        case (opcode)
            OPCODE_RTYPE:                          fmt = FMT_R;
            OPCODE_ITYPE, OPCODE_LOAD, OPCODE_JALR: fmt = FMT_I;
            OPCODE_STORE:                          fmt = FMT_S;
            OPCODE_BRANCH:                         fmt = FMT_B;
            OPCODE_LUI, OPCODE_AUIPC:              fmt = FMT_U;
            OPCODE_JAL:                            fmt = FMT_J;
            default:                               fmt = FMT_X;
        endcase
        return fmt;
    endfunction

    function automatic logic is_shift_imm(input logic [6:0] opcode, input logic [2:0] funct3);
        return (opcode == OPCODE_ITYPE) &&
               ((funct3 == FUNCT3_SLL) || (funct3 == FUNCT3_SRL_SRA));
    endfunction

endpackage

// File: rtl/decode_fields.sv
// Combinational decoder: raw instruction word to decoded_bundle_t, including immediates.
// Illegal-opcode/funct7 flagging is compiled in with DECODE_ILLEGAL_CHECK_EN.
module decode_fields
    import decode_queue_pkg::*;
(
    input  logic [XLEN-1:0] insn,
    output decoded_bundle_t bundle
);

    insn_fmt_e fmt;
    logic      shift_imm;

    assign fmt       = opcode_fmt(insn[6:0]);
    assign shift_imm = is_shift_imm(insn[6:0], insn[14:12]);

    // Unknown opcodes keep raw register fields but claim no operands.
    always_comb begin
        bundle           = '0;
        bundle.insn      = insn;
        bundle.opcode    = insn[6:0];
        bundle.rd        = insn[11:7];
        bundle.rs1       = insn[19:15];
        bundle.rs2       = insn[24:20];
        bundle.funct3    = insn[14:12];
        bundle.funct7    = insn[31:25];
        bundle.shamt     = shift_imm ? insn[24:20] : 5'd0;

        case (fmt)
            FMT_R: begin
                bundle.uses_rs1  = 1'b1;
                bundle.uses_rs2  = 1'b1;
                bundle.writes_rd = 1'b1;
            end
            FMT_I: begin
                bundle.rs2       = 5'd0;
                bundle.uses_rs1  = 1'b1;
                bundle.writes_rd = 1'b1;
                bundle.imm       = {{20{insn[31]}}, insn[31:20]};
            end
            FMT_S: begin
                bundle.rd        = 5'd0;
                bundle.uses_rs1  = 1'b1;
                bundle.uses_rs2  = 1'b1;
                bundle.imm       = {{20{insn[31]}}, insn[31:25], insn[11:7]};
            end
            FMT_B: begin
                bundle.rd        = 5'd0;
                bundle.uses_rs1  = 1'b1;
                bundle.uses_rs2  = 1'b1;
                bundle.imm       = {{19{insn[31]}}, insn[31], insn[7],
                                    insn[30:25], insn[11:8], 1'b0};
            end
            FMT_U: begin
                bundle.rs1       = 5'd0;
                bundle.rs2       = 5'd0;
                bundle.writes_rd = 1'b1;
                bundle.imm       = {insn[31:12], 12'b0};
            end
            FMT_J: begin
                bundle.rs1       = 5'd0;
                bundle.rs2       = 5'd0;
                bundle.writes_rd = 1'b1;
                bundle.imm       = {{11{insn[31]}}, insn[31], insn[19:12],
                                    insn[20], insn[30:21], 1'b0};
            end
            default: begin
            end
        endcase

        if (bundle.rd == 5'd0) begin
            bundle.writes_rd = 1'b0;
        end

`ifdef DECODE_ILLEGAL_CHECK_EN
        bundle.illegal = (fmt == FMT_X) ||
                         (((fmt == FMT_R) || shift_imm) &&
                          (insn[31:25] != FUNCT7_BASE) && (insn[31:25] != FUNCT7_ALT));
`endif
    end

endmodule

// File: rtl/decode_queue.sv
// Registered decode queue: decodes on push, buffers bundles in a FIFO, stalls on load-use.
// Optional illegal-instruction flag via DECODE_ILLEGAL_CHECK_EN (default: illegal_o = 0).
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DWIDTH-1:0] insn_i,
    input  logic [AWIDTH-1:0] pc_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [AWIDTH-1:0] pc_o,
    output logic [DWIDTH-1:0] insn_o,
    output logic [6:0]        opcode_o,
    output logic [4:0]        rd_o,
    output logic [4:0]        rs1_o,
    output logic [4:0]        rs2_o,
    output logic [2:0]        funct3_o,
    output logic [6:0]        funct7_o,
    output logic [4:0]        shamt_o,
    output logic [DWIDTH-1:0] imm_o,
    output logic              uses_rs1_o,
    output logic              uses_rs2_o,
    output logic              writes_rd_o,
    input  logic              ex_is_load_i,
    input  logic [4:0]        ex_rd_i,
    output logic              illegal_o
);

    localparam int PTRW = $clog2(DEPTH);
    localparam logic [PTRW:0] FULL_COUNT = (PTRW + 1)'(DEPTH);
    localparam logic [PTRW:0] PTR_ONE    = (PTRW + 1)'(1);

    if (DWIDTH != 32) begin : g_bad_dwidth
        $error("decode_queue: DWIDTH must be 32");
    end
    if ((DEPTH < 2) || ((1 << PTRW) != DEPTH)) begin : g_bad_depth
        $error("decode_queue: DEPTH must be a power of two and at least 2");
    end

    decoded_bundle_t   in_bundle;
    decoded_bundle_t   head;
    decoded_bundle_t   mem_bundle [DEPTH];
    logic [AWIDTH-1:0] mem_pc     [DEPTH];
    logic [PTRW:0]     wr_ptr;
    logic [PTRW:0]     rd_ptr;
    logic [PTRW:0]     count;
    logic              empty;
    logic              full;
    logic              hazard;
    logic              push;
    logic              pop;

    decode_fields u_decode_fields (
        .insn   (insn_i),
        .bundle (in_bundle)
    );

    assign count = wr_ptr - rd_ptr;
    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);
    assign head  = mem_bundle[rd_ptr[PTRW-1:0]];

    // Load-use: the head cannot leave while the load in execute will write one of its sources.
    assign hazard = ex_is_load_i && (ex_rd_i != 5'd0) &&
                    ((head.uses_rs1 && (head.rs1 == ex_rd_i)) ||
                     (head.uses_rs2 && (head.rs2 == ex_rd_i)));

    assign out_valid_o = !empty && !hazard;
    assign pop         = out_valid_o && out_ready_i;
    assign in_ready_o  = !full || pop;
    assign push        = in_valid_i && in_ready_o && !flush_i;

    // Reset zeroes every slot so the idle head presents all-zero outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_bundle[i] <= '0;
                mem_pc[i]     <= '0;
            end
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem_bundle[wr_ptr[PTRW-1:0]] <= in_bundle;
                mem_pc[wr_ptr[PTRW-1:0]]     <= pc_i;
                wr_ptr                       <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    assign pc_o        = mem_pc[rd_ptr[PTRW-1:0]];
    assign insn_o      = head.insn;
    assign opcode_o    = head.opcode;
    assign rd_o        = head.rd;
    assign rs1_o       = head.rs1;
    assign rs2_o       = head.rs2;
    assign funct3_o    = head.funct3;
    assign funct7_o    = head.funct7;
    assign shamt_o     = head.shamt;
    assign imm_o       = head.imm;
    assign uses_rs1_o  = head.uses_rs1;
    assign uses_rs2_o  = head.uses_rs2;
    assign writes_rd_o = head.writes_rd;

`ifdef DECODE_ILLEGAL_CHECK_EN
    assign illegal_o = head.illegal;
`else
    assign illegal_o = 1'b0;
`endif

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: queue-based reference model plus directed literal checks.
// Expectations for illegal_o follow DECODE_ILLEGAL_CHECK_EN.
module tb_decode_queue;

    localparam int DEPTH = 2;

    localparam int K_R = 0;
    localparam int K_I = 1;
    localparam int K_S = 2;
    localparam int K_B = 3;
    localparam int K_U = 4;
    localparam int K_J = 5;
    localparam int K_X = 6;

    localparam logic [31:0] ADDI  = 32'h00510093;
    localparam logic [31:0] ADD   = 32'h002081B3;
    localparam logic [31:0] SUB   = 32'h40118233;
    localparam logic [31:0] LUI   = 32'h123452B7;
    localparam logic [31:0] SW    = 32'h0050A023;
    localparam logic [31:0] JAL   = 32'hFFDFF0EF;
    localparam logic [31:0] SRAI  = 32'h4033D313;
    localparam logic [31:0] BEQ   = 32'hFE208CE3;
    localparam logic [31:0] BADR  = 32'h7E2081B3;
    localparam logic [31:0] ONES  = 32'hFFFFFFFF;

`ifdef DECODE_ILLEGAL_CHECK_EN
    localparam logic ILL_EN = 1'b1;
`else
    localparam logic ILL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] insn_i;
    logic [31:0] pc_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] pc_o;
    logic [31:0] insn_o;
    logic [6:0]  opcode_o;
    logic [4:0]  rd_o, rs1_o, rs2_o;
    logic [2:0]  funct3_o;
    logic [6:0]  funct7_o;
    logic [4:0]  shamt_o;
    logic [31:0] imm_o;
    logic        uses_rs1_o, uses_rs2_o, writes_rd_o;
    logic        ex_is_load_i;
    logic [4:0]  ex_rd_i;
    logic        illegal_o;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] imm;
        logic [6:0]  opcode;
        logic [6:0]  funct7;
        logic [2:0]  funct3;
        logic [4:0]  rd, rs1, rs2, shamt;
        logic        u1, u2, wr, ill;
    } exp_t;

    exp_t q[$];
    bit   model_ready = 1'b0;
    bit   zero_head   = 1'b0;
    int   checks      = 0;
    int   failures    = 0;

    decode_queue #(.DWIDTH(32), .AWIDTH(32), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .insn_i       (insn_i),
        .pc_i         (pc_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .pc_o         (pc_o),
        .insn_o       (insn_o),
        .opcode_o     (opcode_o),
        .rd_o         (rd_o),
        .rs1_o        (rs1_o),
        .rs2_o        (rs2_o),
        .funct3_o     (funct3_o),
        .funct7_o     (funct7_o),
        .shamt_o      (shamt_o),
        .imm_o        (imm_o),
        .uses_rs1_o   (uses_rs1_o),
        .uses_rs2_o   (uses_rs2_o),
        .writes_rd_o  (writes_rd_o),
        .ex_is_load_i (ex_is_load_i),
        .ex_rd_i      (ex_rd_i),
        .illegal_o    (illegal_o)
    );

    always #5 clk = ~clk;

    // Reference decode built from the format rules with signed arithmetic.
    function automatic exp_t model_decode(input logic [31:0] w, input logic [31:0] pc);
        exp_t        e;
        int          kind;
        logic [31:0] sx;
        logic        shift;
        e.pc     = pc;
        e.insn   = w;
        e.opcode = w[6:0];
        e.funct3 = w[14:12];
        e.funct7 = w[31:25];
        e.rd     = w[11:7];
        e.rs1    = w[19:15];
        e.rs2    = w[24:20];
        case (w[6:0])
            7'h33:               kind = K_R;
            7'h13, 7'h03, 7'h67: kind = K_I;
            7'h23:               kind = K_S;
            7'h63:               kind = K_B;
            7'h37, 7'h17:        kind = K_U;
            7'h6F:               kind = K_J;
            default:             kind = K_X;
        endcase
        shift   = (w[6:0] == 7'h13) && (w[14:12] == 3'd1 || w[14:12] == 3'd5);
        e.shamt = shift ? w[24:20] : 5'd0;
        e.u1 = (kind == K_R) || (kind == K_I) || (kind == K_S) || (kind == K_B);
        e.u2 = (kind == K_R) || (kind == K_S) || (kind == K_B);
        if (kind != K_X && !e.u1) e.rs1 = 5'd0;
        if (kind != K_X && !e.u2) e.rs2 = 5'd0;
        if (kind == K_S || kind == K_B) e.rd = 5'd0;
        e.wr = ((kind == K_R) || (kind == K_I) || (kind == K_U) || (kind == K_J)) && (e.rd != 5'd0);
        case (kind)
            K_I: begin
                sx = $signed(w) >>> 20;
                e.imm = sx;
            end
            K_S: begin
                sx = $signed(w) >>> 25;
                e.imm = (sx << 5) | 32'(w[11:7]);
            end
            K_B: begin
                sx = $signed(w) >>> 31;
                e.imm = (sx << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
            end
            K_U: e.imm = w & 32'hFFFFF000;
            K_J: begin
                sx = $signed(w) >>> 31;
                e.imm = (sx << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
            end
            default: e.imm = 32'd0;
        endcase
        e.ill = ILL_EN && ((kind == K_X) ||
                ((kind == K_R || shift) && w[31:25] != 7'h00 && w[31:25] != 7'h20));
        return e;
    endfunction

    function automatic bit model_hazard();
        exp_t h;
        if (q.size() == 0) return 1'b0;
        h = q[0];
        return ex_is_load_i && (ex_rd_i != 5'd0) &&
               ((h.u1 && h.rs1 == ex_rd_i) || (h.u2 && h.rs2 == ex_rd_i));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] w, input logic [31:0] pc,
                                 input logic ordy, input logic ld, input logic [4:0] exrd,
                                 input logic fl);
        in_valid_i   = v;
        insn_i       = w;
        pc_i         = pc;
        out_ready_i  = ordy;
        ex_is_load_i = ld;
        ex_rd_i      = exrd;
        flush_i      = fl;
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic waitSample();
        @(negedge clk);
    endtask

    // Model state advances on the same edge the DUT samples its inputs.
    always @(posedge clk) begin
        bit m_pop;
        bit m_push;
        if (rst) begin
            q.delete();
            zero_head   = 1'b1;
            model_ready = 1'b1;
        end else if (model_ready) begin
            m_pop  = (q.size() > 0) && !model_hazard() && out_ready_i;
            m_push = in_valid_i && ((q.size() < DEPTH) || m_pop) && !flush_i;
            if (flush_i) begin
                q.delete();
            end else begin
                if (m_pop) void'(q.pop_front());
                if (m_push) begin
                    q.push_back(model_decode(insn_i, pc_i));
                    zero_head = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        bit   exp_valid;
        exp_t h;
        if (model_ready) begin
            exp_valid = (q.size() > 0) && !model_hazard();
            checkOutput("out_valid", 32'(out_valid_o), 32'(exp_valid));
            checkOutput("in_ready", 32'(in_ready_o),
                        32'((q.size() < DEPTH) || (exp_valid && out_ready_i)));
            if (q.size() > 0) begin
                h = q[0];
                checkOutput("pc", pc_o, h.pc);
                checkOutput("insn", insn_o, h.insn);
                checkOutput("opcode", 32'(opcode_o), 32'(h.opcode));
                checkOutput("rd", 32'(rd_o), 32'(h.rd));
                checkOutput("rs1", 32'(rs1_o), 32'(h.rs1));
                checkOutput("rs2", 32'(rs2_o), 32'(h.rs2));
                checkOutput("funct3", 32'(funct3_o), 32'(h.funct3));
                checkOutput("funct7", 32'(funct7_o), 32'(h.funct7));
                checkOutput("shamt", 32'(shamt_o), 32'(h.shamt));
                checkOutput("imm", imm_o, h.imm);
                checkOutput("flags", {29'd0, uses_rs1_o, uses_rs2_o, writes_rd_o},
                            {29'd0, h.u1, h.u2, h.wr});
                checkOutput("illegal", 32'(illegal_o), 32'(h.ill));
            end else if (zero_head) begin
                checkOutput("idle_pc", pc_o, 32'd0);
                checkOutput("idle_insn", insn_o, 32'd0);
                checkOutput("idle_imm", imm_o, 32'd0);
                checkOutput("idle_fields", {17'd0, rd_o, rs1_o, rs2_o},  32'd0);
                checkOutput("idle_flags", {28'd0, uses_rs1_o, uses_rs2_o, writes_rd_o, illegal_o}, 32'd0);
            end
        end
    end

    logic [31:0] table_insn [6];

    initial begin
        table_insn[0] = ADD;  table_insn[1] = SW;  table_insn[2] = ADDI;
        table_insn[3] = BEQ;  table_insn[4] = LUI; table_insn[5] = SRAI;

        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        waitCycle();
        waitCycle();
        waitSample();
        checkOutput("lit_reset_valid", 32'(out_valid_o), 32'd0);
        checkOutput("lit_reset_ready", 32'(in_ready_o), 32'd1);
        checkOutput("lit_reset_insn", insn_o, 32'd0);
        waitCycle();
        rst = 1'b0;

        // addi x1,x2,5
        applyStimulus(1, ADDI, 32'h1000, 1, 0, 0, 0);
        waitCycle();
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        waitSample();
        checkOutput("lit_addi_valid", 32'(out_valid_o), 32'd1);
        checkOutput("lit_addi_rd", 32'(rd_o), 32'd1);
        checkOutput("lit_addi_rs1", 32'(rs1_o), 32'd2);
        checkOutput("lit_addi_rs2", 32'(rs2_o), 32'd0);
        checkOutput("lit_addi_imm", imm_o, 32'd5);
        checkOutput("lit_addi_uses_rs2", 32'(uses_rs2_o), 32'd0);
        checkOutput("lit_addi_writes_rd", 32'(writes_rd_o), 32'd1);
        checkOutput("lit_addi_pc", pc_o, 32'h1000);
        waitCycle();

        // Fill to DEPTH with execute stalled, then release.
        applyStimulus(1, ADD, 32'h2000, 0, 0, 0, 0);
        waitCycle();
        applyStimulus(1, SUB, 32'h2004, 0, 0, 0, 0);
        waitCycle();
        applyStimulus(1, LUI, 32'h2008, 0, 0, 0, 0);
        waitSample();
        checkOutput("lit_full_ready", 32'(in_ready_o), 32'd0);
        waitCycle();
        waitSample();
        checkOutput("lit_full_ready_hold", 32'(in_ready_o), 32'd0);
        waitCycle();
        applyStimulus(1, LUI, 32'h2008, 1, 0, 0, 0);
        waitSample();
        checkOutput("lit_full_ready_pop", 32'(in_ready_o), 32'd1);
        waitCycle();
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        waitSample();
        checkOutput("lit_order_second", pc_o, 32'h2004);
        waitCycle();
        waitSample();
        checkOutput("lit_order_third", pc_o, 32'h2008);
        checkOutput("lit_lui_imm", imm_o, 32'h12345000);
        waitCycle();

        // Load-use hazard on sw x5,0(x1).
        applyStimulus(1, SW, 32'h3000, 1, 1, 5'd5, 0);
        waitCycle();
        applyStimulus(0, 0, 0, 1, 1, 5'd5, 0);
        waitSample();
        checkOutput("lit_hazard_valid", 32'(out_valid_o), 32'd0);
        waitCycle();
        waitSample();
        checkOutput("lit_hazard_held_insn", insn_o, SW);
        waitCycle();
        applyStimulus(0, 0, 0, 1, 0, 5'd5, 0);
        waitSample();
        checkOutput("lit_release_valid", 32'(out_valid_o), 32'd1);
        checkOutput("lit_sw_rd", 32'(rd_o), 32'd0);
        checkOutput("lit_sw_imm", imm_o, 32'd0);
        waitCycle();
        applyStimulus(1, SW, 32'h3004, 1, 1, 5'd0, 0);
        waitCycle();
        applyStimulus(0, 0, 0, 1, 1, 5'd0, 0);
        waitSample();
        checkOutput("lit_x0_no_stall", 32'(out_valid_o), 32'd1);
        waitCycle();

        // Flush with a full queue and a competing push.
        applyStimulus(1, ADDI, 32'h4000, 0, 0, 0, 0);
        waitCycle();
        applyStimulus(1, JAL, 32'h4004, 0, 0, 0, 0);
        waitCycle();
        applyStimulus(1, SRAI, 32'h4008, 1, 0, 0, 1);
        waitCycle();
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        waitSample();
        checkOutput("lit_flush_valid", 32'(out_valid_o), 32'd0);
        checkOutput("lit_flush_ready", 32'(in_ready_o), 32'd1);
        waitCycle();
        waitSample();
        checkOutput("lit_flush_dropped", 32'(out_valid_o), 32'd0);
        waitCycle();

        // jal x1,-4 then a full queue hit by reset.
        applyStimulus(1, JAL, 32'h5000, 0, 0, 0, 0);
        waitCycle();
        applyStimulus(1, SRAI, 32'h5004, 0, 0, 0, 0);
        waitSample();
        checkOutput("lit_jal_imm", imm_o, 32'hFFFFFFFC);
        checkOutput("lit_jal_rs", {27'd0, rs1_o | rs2_o}, 32'd0);
        checkOutput("lit_jal_writes_rd", 32'(writes_rd_o), 32'd1);
        waitCycle();
        applyStimulus(1, BEQ, 32'h5008, 0, 0, 0, 0);
        rst = 1'b1;
        waitCycle();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        waitSample();
        checkOutput("lit_rst_valid", 32'(out_valid_o), 32'd0);
        checkOutput("lit_rst_ready", 32'(in_ready_o), 32'd1);
        checkOutput("lit_rst_pc", pc_o, 32'd0);
        checkOutput("lit_rst_imm", imm_o, 32'd0);
        waitCycle();

        // Unknown opcode, shift-immediate and bad R-type funct7.
        applyStimulus(1, ONES, 32'h6000, 0, 0, 0, 0);
        waitCycle();
        applyStimulus(1, SRAI, 32'h6004, 1, 0, 0, 0);
        waitSample();
        checkOutput("lit_ones_illegal", 32'(illegal_o), 32'(ILL_EN));
        checkOutput("lit_ones_flags", {29'd0, uses_rs1_o, uses_rs2_o, writes_rd_o}, 32'd0);
        waitCycle();
        applyStimulus(1, BADR, 32'h6008, 1, 0, 0, 0);
        waitSample();
        checkOutput("lit_srai_shamt", 32'(shamt_o), 32'd3);
        checkOutput("lit_srai_imm", imm_o, 32'h00000403);
        waitCycle();
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        waitSample();
        checkOutput("lit_badr_illegal", 32'(illegal_o), 32'(ILL_EN));
        waitCycle();

        // Mixed traffic: table-driven pushes with intermittent backpressure and load hazards.
        for (int i = 0; i < 48; i++) begin
            applyStimulus((i % 3) != 2, table_insn[i % 6], 32'h7000 + 32'(i * 4),
                          (i % 4) != 1, (i % 5) == 0, 5'((i % 7) + 1), i == 30);
            waitCycle();
        end
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        repeat (4) waitCycle();
        waitSample();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
